// File: rtl/axi_mem_master.sv
// rtl/axi_mem_master.sv - single-outstanding AXI4 memory master; burst reads enabled by AXI_MEM_MASTER_BURST_EN
module axi_mem_master #(
    parameter logic [3:0]  AXI_ID  = 4'h0,
    parameter int unsigned MAX_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    // client request / response
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_size,
    input  logic [1:0]  req_len,
    output logic        resp_valid,
    output logic        resp_last,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    // AW channel
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    // W channel
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    // B channel
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    input  logic [3:0]  bid,
    // AR channel
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    // R channel
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } state_e;

    // Largest legal burst length, saturated to what the 2-bit req_len can express
    localparam logic [1:0] MAX_LEN_C = (MAX_LEN > 3) ? 2'd3 : MAX_LEN[1:0];

    state_e      state_q, state_d;
    logic        arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  size_q;
    logic [7:0]  beat_q;

    logic        accept;
    logic        rd_beat;
    logic        rd_final;
    logic        exp_last;
    logic        aw_done, w_done;
    logic        resp_valid_c, resp_last_c, resp_err_c;

    assign accept   = (state_q == IDLE) && req_valid;
    assign rd_beat  = (state_q == RDATA) && rvalid && rready_q;
    assign exp_last = (beat_q == arlen);
    // A channel counts as done once its valid has dropped, or it handshakes this cycle
    assign aw_done  = !awvalid_q || awready;
    assign w_done   = !wvalid_q || wready;

`ifdef AXI_MEM_MASTER_BURST_EN
    logic [1:0] len_q, len_d;
    logic       unused_ids;

    assign len_d = (req_len > MAX_LEN_C) ? MAX_LEN_C : req_len;

    // Clamped burst length captured with the rest of the request
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= 2'd0;
        end else if (accept) begin
            len_q <= len_d;
        end
    end

    assign arlen      = {6'b0, len_q};
    assign rd_final   = rlast;
    assign unused_ids = ^{bid, rid};
`else
    logic unused_ids;

    // Single-beat reads only: the first beat always closes the transaction
    assign arlen      = 8'd0;
    assign rd_final   = 1'b1;
    assign unused_ids = ^{bid, rid, req_len, MAX_LEN_C};
`endif

    // Next state and per-beat response generation
    always_comb begin
        state_d      = state_q;
        resp_valid_c = 1'b0;
        resp_last_c  = 1'b0;
        resp_err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_wen ? WADDR : RADDR;
                end
            end
            RADDR: begin
                if (arvalid_q && arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (rd_beat) begin
                    resp_valid_c = 1'b1;
                    resp_last_c  = rd_final;
                    resp_err_c   = (rresp != 2'b00) || (rlast != exp_last);
                    if (rd_final) begin
                        state_d = IDLE;
                    end
                end
            end
            WADDR: begin
                if (aw_done && w_done) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (bvalid && bready_q) begin
                    resp_valid_c = 1'b1;
                    resp_last_c  = 1'b1;
                    resp_err_c   = (bresp != 2'b00);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered AXI handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= (state_d == RADDR);
            rready_q  <= (state_d == RDATA);
            bready_q  <= (state_d == WRESP);
            if (accept && req_wen) begin
                awvalid_q <= 1'b1;
            end else if (awvalid_q && awready) begin
                awvalid_q <= 1'b0;
            end
            if (accept && req_wen) begin
                wvalid_q <= 1'b1;
            end else if (wvalid_q && wready) begin
                wvalid_q <= 1'b0;
            end
        end
    end

    // Request payload held stable from acceptance until the next request
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            size_q  <= 3'd0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            size_q  <= req_size;
        end
    end

    // Read beat counter, restarted for every accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= 8'd0;
        end else if (accept) begin
            beat_q <= 8'd0;
        end else if (rd_beat) begin
            beat_q <= beat_q + 8'd1;
        end
    end

    assign req_ready  = (state_q == IDLE);
    // Responses are suppressed while reset is held so an abandoned read reports nothing
    assign resp_valid = resp_valid_c && !reset;
    assign resp_last  = resp_last_c && !reset;
    assign resp_err   = resp_err_c && !reset;
    assign resp_rdata = rdata;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;

    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    assign bready  = bready_q;

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arid    = AXI_ID;
    assign arsize  = size_q;
    assign arburst = 2'b01;

    assign rready  = rready_q;

endmodule

// File: tb/tb_axi_mem_master.sv
// tb/tb_axi_mem_master.sv - directed self-checking bench for axi_mem_master
module tb_axi_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_size;
    logic [1:0]  req_len;
    logic        resp_valid, resp_last, resp_err;
    logic [31:0] resp_rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef AXI_MEM_MASTER_BURST_EN
    localparam logic [7:0] EXP_LEN3 = 8'd3;
`else
    localparam logic [7:0] EXP_LEN3 = 8'd0;
`endif

    always #5 clk = ~clk;

    axi_mem_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_size(req_size), .req_len(req_len),
        .resp_valid(resp_valid), .resp_last(resp_last), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle, then scrub the inputs so latching is exercised
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [1:0] len);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
        req_wstrb = strb; req_size = 3'd2; req_len = len;
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1'b1);
        next_cycle();
        req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_wstrb = 4'd0; req_size = 3'd0; req_len = 2'd0;
    endtask

    task automatic ar_hs(input logic [31:0] exp_addr, input logic [7:0] exp_len);
        arready = 1'b1;
        @(negedge clk);
        check_eq("arvalid", arvalid, 1'b1);
        check_eq("araddr", araddr, exp_addr);
        check_eq("arlen", arlen, exp_len);
        check_eq("arsize", arsize, 3'd2);
        check_eq("arburst", arburst, 2'b01);
        check_eq("arid", arid, 4'h0);
        check_eq("req_ready_busy", req_ready, 1'b0);
        next_cycle();
        arready = 1'b0;
    endtask

    task automatic rbeat(input string tag, input logic [31:0] d, input logic [1:0] rr,
                         input logic rl, input logic exp_last, input logic exp_err);
        rvalid = 1'b1; rdata = d; rresp = rr; rlast = rl;
        @(negedge clk);
        check_eq({tag, "_rready"}, rready, 1'b1);
        check_eq({tag, "_vld"}, resp_valid, 1'b1);
        check_eq({tag, "_data"}, resp_rdata, d);
        check_eq({tag, "_last"}, resp_last, exp_last);
        check_eq({tag, "_err"}, resp_err, exp_err);
        next_cycle();
        rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check_eq({tag, "_req_ready"}, req_ready, 1'b1);
        check_eq({tag, "_rready"}, rready, 1'b0);
        check_eq({tag, "_bready"}, bready, 1'b0);
        check_eq({tag, "_resp_valid"}, resp_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        req_wstrb = 0; req_size = 0; req_len = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 4'h5;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 4'h7;

        @(negedge clk);
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_awvalid", awvalid, 1'b0);
        check_eq("rst_wvalid", wvalid, 1'b0);
        check_eq("rst_rready", rready, 1'b0);
        check_eq("rst_bready", bready, 1'b0);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        next_cycle();
        reset = 1'b0;
        check_idle("post_rst");
        next_cycle();

        // single-beat read
        issue(1'b0, 32'h8000_0000, 32'd0, 4'd0, 2'd0);
        ar_hs(32'h8000_0000, 8'd0);
        rbeat("rd1", 32'h0000_0413, 2'b00, 1'b1, 1'b1, 1'b0);
        check_idle("rd1_done");
        next_cycle();

`ifdef AXI_MEM_MASTER_BURST_EN
        // four-beat burst read
        issue(1'b0, 32'h8000_0010, 32'd0, 4'd0, 2'd3);
        ar_hs(32'h8000_0010, 8'd3);
        rbeat("bst0", 32'h11, 2'b00, 1'b0, 1'b0, 1'b0);
        rbeat("bst1", 32'h22, 2'b00, 1'b0, 1'b0, 1'b0);
        rbeat("bst2", 32'h33, 2'b00, 1'b0, 1'b0, 1'b0);
        rbeat("bst3", 32'h44, 2'b00, 1'b1, 1'b1, 1'b0);
        check_idle("bst_done");
        next_cycle();

        // slave error on beat 0, early rlast on beat 2
        issue(1'b0, 32'h8000_0020, 32'd0, 4'd0, 2'd3);
        ar_hs(32'h8000_0020, EXP_LEN3);
        rbeat("err0", 32'h55, 2'b10, 1'b0, 1'b0, 1'b1);
        rbeat("err1", 32'h66, 2'b00, 1'b0, 1'b0, 1'b0);
        rbeat("err2", 32'h77, 2'b00, 1'b1, 1'b1, 1'b1);
        check_idle("err_done");
        next_cycle();
`else
        // slave error; req_len ignored
        issue(1'b0, 32'h8000_0020, 32'd0, 4'd0, 2'd3);
        ar_hs(32'h8000_0020, EXP_LEN3);
        rbeat("err0", 32'h55, 2'b10, 1'b1, 1'b1, 1'b1);
        check_idle("err0_done");
        next_cycle();

        // missing rlast still closes a single-beat read, flagged as error
        issue(1'b0, 32'h8000_0024, 32'd0, 4'd0, 2'd0);
        ar_hs(32'h8000_0024, 8'd0);
        rbeat("nolast", 32'h66, 2'b00, 1'b0, 1'b1, 1'b1);
        check_idle("nolast_done");
        next_cycle();
`endif

        // write, awready three cycles ahead of wready
        issue(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 2'd0);
        awready = 1'b1;
        @(negedge clk);
        check_eq("w1_awvalid", awvalid, 1'b1);
        check_eq("w1_wvalid", wvalid, 1'b1);
        check_eq("w1_awaddr", awaddr, 32'h8000_0100);
        check_eq("w1_awlen", awlen, 8'd0);
        check_eq("w1_awsize", awsize, 3'd2);
        check_eq("w1_awburst", awburst, 2'b01);
        check_eq("w1_awid", awid, 4'h0);
        check_eq("w1_wdata", wdata, 32'hDEAD_BEEF);
        check_eq("w1_wstrb", wstrb, 4'b0011);
        check_eq("w1_wlast", wlast, 1'b1);
        next_cycle();
        awready = 1'b0;
        @(negedge clk);
        check_eq("w1_aw_dropped", awvalid, 1'b0);
        check_eq("w1_w_held_a", wvalid, 1'b1);
        next_cycle();
        @(negedge clk);
        check_eq("w1_w_held_b", wvalid, 1'b1);
        check_eq("w1_wdata_stable", wdata, 32'hDEAD_BEEF);
        next_cycle();
        wready = 1'b1;
        @(negedge clk);
        check_eq("w1_w_held_c", wvalid, 1'b1);
        check_eq("w1_no_bready", bready, 1'b0);
        next_cycle();
        wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        check_eq("w1_w_dropped", wvalid, 1'b0);
        check_eq("w1_bready", bready, 1'b1);
        check_eq("w1_resp_valid", resp_valid, 1'b1);
        check_eq("w1_resp_last", resp_last, 1'b1);
        check_eq("w1_resp_err", resp_err, 1'b0);
        next_cycle();
        bvalid = 1'b0;
        check_idle("w1_done");
        next_cycle();

        // write, W before AW, slave error response
        issue(1'b1, 32'h8000_0104, 32'h1234_5678, 4'hF, 2'd0);
        wready = 1'b1;
        @(negedge clk);
        check_eq("w2_awvalid", awvalid, 1'b1);
        check_eq("w2_wvalid", wvalid, 1'b1);
        next_cycle();
        wready = 1'b0; awready = 1'b1;
        @(negedge clk);
        check_eq("w2_w_dropped", wvalid, 1'b0);
        check_eq("w2_aw_held", awvalid, 1'b1);
        check_eq("w2_awaddr", awaddr, 32'h8000_0104);
        next_cycle();
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        check_eq("w2_aw_dropped", awvalid, 1'b0);
        check_eq("w2_resp_valid", resp_valid, 1'b1);
        check_eq("w2_resp_err", resp_err, 1'b1);
        check_eq("w2_resp_last", resp_last, 1'b1);
        next_cycle();
        bvalid = 1'b0; bresp = 2'b00;
        check_idle("w2_done");
        next_cycle();

        // reset while in RDATA abandons the read
        issue(1'b0, 32'h8000_0030, 32'd0, 4'd0, 2'd3);
        ar_hs(32'h8000_0030, EXP_LEN3);
`ifdef AXI_MEM_MASTER_BURST_EN
        rbeat("rst_b0", 32'h99, 2'b00, 1'b0, 1'b0, 1'b0);
`endif
        rvalid = 1'b1; rdata = 32'hAA; rlast = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_resp_valid", resp_valid, 1'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_rready", rready, 1'b0);
        check_eq("midrst_req_ready", req_ready, 1'b1);
        check_eq("midrst_resp_valid2", resp_valid, 1'b0);
        check_eq("midrst_arvalid", arvalid, 1'b0);
        next_cycle();
        rvalid = 1'b0;
        @(negedge clk);
        check_eq("midrst_quiet", resp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_master.md
AXI_MEM_MASTER -- requirements
Module: axi_mem_master

Interface
REQ-001 Parameter AXI_ID, default 4'h0: value driven on awid/arid; bid/rid SHALL be ignored.
REQ-002 Parameter MAX_LEN, default 3: largest accepted req_len, i.e. beats minus 1.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  client request handshake.
REQ-006 req_wen  in  1  1 = write, 0 = read.
REQ-007 req_addr, req_wdata  in  32 each  byte address and write data.
REQ-008 req_wstrb, req_size, req_len  in  4/3/2  byte strobes, AXI size code, and read beats minus 1.
REQ-009 resp_valid, resp_last, resp_err  out  1 each  response beat, final beat, error flag.
REQ-010 resp_rdata  out  32  read beat data.
REQ-011 AW: awvalid out 1, awready in 1, awaddr out 32, awid out 4, awlen out 8, awsize out 3, awburst out 2.
REQ-012 W: wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1.
REQ-013 B: bvalid in 1, bready out 1, bresp in 2, bid in 4.
REQ-014 AR: arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3, arburst out 2.
REQ-015 R: rvalid in 1, rready out 1, rdata in 32, rresp in 2, rlast in 1, rid in 4.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, RADDR, RDATA, WADDR, WRESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid&req_ready, and all req_* fields SHALL be latched at acceptance.
REQ-018 A read SHALL go IDLE->RADDR; arvalid SHALL be high from the next cycle until the arready handshake, then the FSM goes to RDATA.
REQ-019 A write SHALL go IDLE->WADDR; awvalid and wvalid SHALL both rise the next cycle, and each SHALL drop independently after its own handshake.
REQ-020 WADDR->WRESP SHALL occur when both the AW and W handshakes are done, in the same cycle or different cycles.
REQ-021 Write bursts: awlen=0, wlast=1, wdata/wstrb from latched values.
REQ-022 awburst and arburst SHALL be 2'b01 (INCR); awsize/arsize SHALL equal the latched req_size.
REQ-023 rready SHALL be 1 in RDATA only; bready SHALL be 1 in WRESP only.
REQ-024 On each rvalid&rready, resp_valid SHALL be 1 in the same cycle, with resp_rdata=rdata and resp_last=rlast; the client SHALL NOT backpressure.
REQ-025 An 8-bit beat counter SHALL compare against arlen; resp_err SHALL be set on that beat if rresp!=0 or rlast mismatches the count.
REQ-026 On rlast, RDATA->IDLE; a missing rlast SHALL keep the FSM in RDATA.
REQ-027 On bvalid in WRESP: resp_valid=1, resp_last=1, resp_err=(bresp!=0), then WRESP->IDLE.
REQ-028 req_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-029 AXI outputs SHALL be registered; payload SHALL stay stable while the matching valid is high.

Reset
REQ-030 reset SHALL force IDLE and clear awvalid, wvalid, arvalid, rready, bready, resp_valid, resp_err and the beat counter.
REQ-031 Reset mid-transaction SHALL abandon the transaction without a response; req_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-032 AXI_MEM_MASTER_BURST_EN defined: arlen={6'b0, clamped req_len}, and multi-beat reads are supported.
REQ-033 AXI_MEM_MASTER_BURST_EN undefined: arlen=0 always, req_len is ignored, and every read returns exactly one beat with resp_last=1.

Verification
REQ-034 Read addr 0x8000_0000, len 0, slave arready=arvalid, rdata 0x0000_0413 -> one resp beat with rdata 0x413, last=1, err=0, req_ready back to 1.
REQ-035 BURST_EN read addr 0x8000_0010, len 3, beats 0x11,0x22,0x33,0x44 -> four resp beats in order, last only on the 4th, arlen=3.
REQ-036 Write addr 0x8000_0100, data 0xDEAD_BEEF, strb 4'b0011, awready 3 cycles before wready -> each valid drops at its own handshake, one resp with last=1.
REQ-037 Read with rresp=2'b10, or rlast on beat 2 of len 3 -> resp_err=1 on that beat.
REQ-038 reset asserted in RDATA after 1 of 4 beats -> next cycle state IDLE, rready=0, and no further resp_valid.
